// File: rtl/mm_mac_if.sv
// Handshake and matrix bus bundle between a 4x4 MAC engine and its matrix register file.
// The master drives the operands and the start/abort controls; the slave returns status and the write-back.
interface mm_mac_if #(
  parameter int ELEM_W = 16,
  parameter int DIM    = 4
);
  localparam int MW = DIM * DIM * ELEM_W;

  logic          start;
  logic          acc;
  logic          abort;
  logic [MW-1:0] a;
  logic [MW-1:0] b;
  logic [MW-1:0] c;
  logic          busy;
  logic          done;
  logic          we_rf;
  logic [1:0]    rd_rf;
  logic [MW-1:0] wdata_mm;

  modport master (
    output start, acc, abort, a, b, c,
    input  busy, done, we_rf, rd_rf, wdata_mm
  );

  modport slave (
    input  start, acc, abort, a, b, c,
    output busy, done, we_rf, rd_rf, wdata_mm
  );
endinterface

// File: rtl/mm_mac_engine.sv
// 4x4 unsigned matrix multiply-accumulate (C = A*B or C += A*B), one result element per cycle.
// Start to write-back is 17 cycles. There is no backpressure: start is ignored while busy.
module mm_mac_engine #(
  parameter int ELEM_W = 16,
  parameter int DIM    = 4
) (
  input  logic    clk,
  input  logic    reset,
  mm_mac_if.slave mm
);
  localparam int NE = DIM * DIM;
  localparam int MW = NE * ELEM_W;
  localparam int IW = $clog2(NE);

  typedef enum logic [1:0] {IDLE, COMPUTE, WRITE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              load;

  logic [MW-1:0]     op_a, op_b, op_c;
  logic              op_acc;
  logic [MW-1:0]     res_q;
  logic [ELEM_W-1:0] elem_sum;

  logic              busy_q, done_q, we_q;
  logic [1:0]        rd_q;
  logic [MW-1:0]     wdata_q;

  // One dot product per cycle: row/column of the element currently indexed.
  always_comb begin
    int row;
    int col;
    row      = int'(idx_q) / DIM;
    col      = int'(idx_q) % DIM;
    elem_sum = op_acc ? op_c[int'(idx_q)*ELEM_W +: ELEM_W] : '0;
    for (int k = 0; k < DIM; k++) begin
      elem_sum = elem_sum + ELEM_W'(op_a[(row*DIM + k)*ELEM_W +: ELEM_W] *
                                    op_b[(k*DIM + col)*ELEM_W +: ELEM_W]);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mm.start && !mm.abort) begin
          state_d = COMPUTE;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      COMPUTE: begin
        if (mm.abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (idx_q == IW'(NE - 1)) begin
          state_d = WRITE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the state, so they trail it by one edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_c    <= '0;
      op_acc  <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 2'd0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        op_a   <= mm.a;
        op_b   <= mm.b;
        op_c   <= mm.c;
        op_acc <= mm.acc;
      end
      if (state_q == COMPUTE && !mm.abort) begin
        res_q[int'(idx_q)*ELEM_W +: ELEM_W] <= elem_sum;
      end
      busy_q <= (state_q == COMPUTE && !mm.abort) || (state_q == WRITE);
      done_q <= (state_q == WRITE);
      we_q   <= (state_q == WRITE);
      if (state_q == WRITE) begin
        rd_q    <= 2'd2;
        wdata_q <= res_q;
      end
    end
  end

  assign mm.busy     = busy_q;
  assign mm.done     = done_q;
  assign mm.we_rf    = we_q;
  assign mm.rd_rf    = rd_q;
  assign mm.wdata_mm = wdata_q;
endmodule

// File: tb/tb_mm_mac_engine.sv
// Directed bench for mm_mac_engine with a cycle-level reference model and literal result checks.
module tb_mm_mac_engine;
  localparam int EW = 16;
  localparam int D  = 4;
  localparam int NE = D * D;
  localparam int MW = NE * EW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mm_mac_if #(.ELEM_W(EW), .DIM(D)) mm ();
  mm_mac_engine #(.ELEM_W(EW), .DIM(D)) u_dut (.clk(clk), .reset(reset), .mm(mm));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Reference model: age = edges since the accepted start, -1 when no operation is live.
  int            m_age = -1;
  logic          m_busy = 1'b0, m_we = 1'b0, m_done = 1'b0;
  logic [1:0]    m_rd = 2'd0;
  logic [MW-1:0] m_wdata = '0, m_res = '0;

  logic [MW-1:0] last_wb = '0;
  int            wb_count = 0;
  int            wb_cyc = 0;
  int            wb_cycs[$];

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                           input logic [MW-1:0] c, input logic acc);
    int unsigned am[D][D];
    int unsigned bm[D][D];
    int unsigned s;
    logic [MW-1:0] res;
    res = '0;
    for (int r = 0; r < D; r++)
      for (int q = 0; q < D; q++) begin
        am[r][q] = int'(a[(r*D + q)*EW +: EW]);
        bm[r][q] = int'(b[(r*D + q)*EW +: EW]);
      end
    for (int r = 0; r < D; r++)
      for (int q = 0; q < D; q++) begin
        s = acc ? int'(c[(r*D + q)*EW +: EW]) : 0;
        for (int k = 0; k < D; k++) s = s + am[r][k] * bm[k][q];
        res[(r*D + q)*EW +: EW] = EW'(s % 65536);
      end
    return res;
  endfunction

  function automatic logic [MW-1:0] fill(input logic [EW-1:0] v);
    logic [MW-1:0] m;
    for (int i = 0; i < NE; i++) m[i*EW +: EW] = v;
    return m;
  endfunction

  function automatic logic [MW-1:0] ramp();
    logic [MW-1:0] m;
    for (int i = 0; i < NE; i++) m[i*EW +: EW] = EW'(i);
    return m;
  endfunction

  function automatic logic [MW-1:0] ident();
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < D; i++) m[(i*D + i)*EW +: EW] = EW'(1);
    return m;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      m_age   <= -1;
      m_busy  <= 1'b0;
      m_we    <= 1'b0;
      m_done  <= 1'b0;
      m_rd    <= 2'd0;
      m_wdata <= '0;
    end else begin
      m_we   <= 1'b0;
      m_done <= 1'b0;
      if (m_age < 0) begin
        m_busy <= 1'b0;
        if (mm.start && !mm.abort) begin
          m_age <= 0;
          m_res <= matmul(mm.a, mm.b, mm.c, mm.acc);
        end
      end else if (m_age == 16) begin
        m_we    <= 1'b1;
        m_done  <= 1'b1;
        m_rd    <= 2'd2;
        m_wdata <= m_res;
        m_busy  <= 1'b1;
        m_age   <= -1;
      end else if (mm.abort) begin
        m_busy <= 1'b0;
        m_age  <= -1;
      end else begin
        m_busy <= 1'b1;
        m_age  <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", MW'(mm.busy), MW'(m_busy));
      chk("we_rf", MW'(mm.we_rf), MW'(m_we));
      chk("done", MW'(mm.done), MW'(m_done));
      chk("rd_rf", MW'(mm.rd_rf), MW'(m_rd));
      chk("wdata_mm", mm.wdata_mm, m_wdata);
      if (mm.we_rf === 1'b1) begin
        last_wb = mm.wdata_mm;
        wb_count++;
        wb_cyc = cyc;
        wb_cycs.push_back(cyc);
      end
    end
  end

  task automatic launch(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [MW-1:0] c,
                        input logic acc, output int s);
    @(negedge clk);
    mm.a = a;
    mm.b = b;
    mm.c = c;
    mm.acc = acc;
    mm.start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    mm.start = 1'b0;
  endtask

  task automatic wait_wb(input int prev, input string name);
    int n;
    n = 0;
    while (wb_count == prev && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_chk++;
    if (wb_count == prev) begin
      n_fail++;
      $display("FAIL %s_timeout: no write-back within 30 cycles, required one", name);
    end
  endtask

  task automatic quiet(input int cycles, input int prev, input string name);
    repeat (cycles) @(negedge clk);
    #1;
    chk(name, MW'(wb_count), MW'(prev));
  endtask

  initial begin
    logic [MW-1:0] z;
    int s, w0, n0;
    z = '0;
    mm.start = 1'b0;
    mm.acc = 1'b0;
    mm.abort = 1'b0;
    mm.a = z;
    mm.b = z;
    mm.c = z;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", MW'(mm.busy), MW'(0));
    chk("reset_rd_rf", MW'(mm.rd_rf), MW'(0));
    chk("reset_wdata", mm.wdata_mm, z);
    reset = 1'b1;

    // Identity * ramp, with latency and single-cycle done
    w0 = wb_count;
    launch(ident(), ramp(), z, 1'b0, s);
    wait_wb(w0, "identity");
    chk("identity_latency", MW'(wb_cyc - s), MW'(17));
    chk("identity_data", last_wb, ramp());
    chk("identity_rd", MW'(mm.rd_rf), MW'(2));
    chk("model_identity", matmul(ident(), ramp(), z, 1'b0), ramp());
    @(negedge clk);
    #1;
    chk("done_one_cycle", MW'(mm.done), MW'(0));
    chk("busy_after_wb", MW'(mm.busy), MW'(0));
    chk("rd_hold", MW'(mm.rd_rf), MW'(2));
    chk("wdata_hold", mm.wdata_mm, ramp());

    // 2*3 summed four times
    w0 = wb_count;
    launch(fill(16'h0002), fill(16'h0003), z, 1'b0, s);
    wait_wb(w0, "twos_threes");
    chk("twos_threes_data", last_wb, fill(16'h0018));
    chk("model_twos_threes", matmul(fill(16'h0002), fill(16'h0003), z, 1'b0), fill(16'h0018));

    // Wrap-around
    w0 = wb_count;
    launch(fill(16'hFFFF), fill(16'hFFFF), z, 1'b0, s);
    wait_wb(w0, "wrap");
    chk("wrap_data", last_wb, fill(16'h0004));
    chk("model_wrap", matmul(fill(16'hFFFF), fill(16'hFFFF), z, 1'b0), fill(16'h0004));

    // Accumulate; operands disturbed after the start edge
    w0 = wb_count;
    launch(ident(), fill(16'h0001), fill(16'h0005), 1'b1, s);
    mm.c = z;
    mm.a = fill(16'h1234);
    mm.b = fill(16'h00FF);
    mm.acc = 1'b0;
    wait_wb(w0, "accumulate");
    chk("accumulate_data", last_wb, fill(16'h0006));
    chk("model_accumulate", matmul(ident(), fill(16'h0001), fill(16'h0005), 1'b1), fill(16'h0006));

    // Abort at element index 8
    w0 = wb_count;
    launch(fill(16'h0001), fill(16'h0001), z, 1'b0, s);
    repeat (8) @(negedge clk);
    mm.abort = 1'b1;
    @(negedge clk);
    mm.abort = 1'b0;
    #1;
    chk("abort_busy_drop", MW'(mm.busy), MW'(0));
    quiet(25, w0, "abort_no_writeback");

    // Reset at element index 8
    w0 = wb_count;
    launch(fill(16'h0001), fill(16'h0001), z, 1'b0, s);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("midreset_busy", MW'(mm.busy), MW'(0));
    chk("midreset_we", MW'(mm.we_rf), MW'(0));
    chk("midreset_rd", MW'(mm.rd_rf), MW'(0));
    chk("midreset_wdata", mm.wdata_mm, z);
    reset = 1'b1;
    quiet(25, w0, "midreset_no_writeback");

    // Abort wins over start in IDLE
    w0 = wb_count;
    @(negedge clk);
    mm.start = 1'b1;
    mm.abort = 1'b1;
    @(negedge clk);
    mm.start = 1'b0;
    mm.abort = 1'b0;
    #1;
    chk("abort_start_busy", MW'(mm.busy), MW'(0));
    quiet(20, w0, "abort_start_no_writeback");

    // Start while busy is ignored
    w0 = wb_count;
    launch(fill(16'h0002), fill(16'h0003), z, 1'b0, s);
    repeat (4) @(negedge clk);
    mm.a = fill(16'h0007);
    mm.start = 1'b1;
    @(negedge clk);
    mm.start = 1'b0;
    wait_wb(w0, "ignored_start");
    chk("ignored_start_data", last_wb, fill(16'h0018));
    quiet(25, w0 + 1, "ignored_start_single_wb");

    // Start held high for 40 cycles
    w0 = wb_count;
    n0 = wb_cycs.size();
    @(negedge clk);
    mm.a = ident();
    mm.b = fill(16'h0009);
    mm.c = z;
    mm.acc = 1'b0;
    mm.start = 1'b1;
    repeat (40) @(negedge clk);
    mm.start = 1'b0;
    #1;
    chk("held_wb_count", MW'(wb_count - w0), MW'(2));
    if (wb_cycs.size() >= n0 + 2) chk("held_spacing", MW'(wb_cycs[n0+1] - wb_cycs[n0]), MW'(18));
    else begin
      n_chk++;
      n_fail++;
      $display("FAIL held_spacing: only %0d write-backs seen, required 2", wb_cycs.size() - n0);
    end
    repeat (25) @(negedge clk);
    #1;
    chk("held_data", last_wb, fill(16'h0009));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mm_mac_engine.md
MM_MAC_ENGINE -- requirements
Module: mm_mac_engine

Interface
REQ-001 Parameter: ELEM_W, 16, element width in bits; fixed at 16 in this release.
REQ-002 Parameter: DIM, 4, matrix dimension; DIM*DIM*ELEM_W SHALL equal 256.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled on rising clk edge only.
REQ-005 Port: start  input  1  request one C = A*B (or C += A*B) operation.
REQ-006 Port: acc  input  1  accumulate mode select, sampled with start.
REQ-007 Port: abort  input  1  cancel in-flight operation, no write-back.
REQ-008 Port: a  input  256  matrix A from matrix register file slot 0.
REQ-009 Port: b  input  256  matrix B from matrix register file slot 1.
REQ-010 Port: c  input  256  matrix C from matrix register file slot 2 (accumulate source).
REQ-011 Port: busy  output  1  high while an operation is in flight.
REQ-012 Port: done  output  1  one-cycle pulse coincident with write-back.
REQ-013 Port: we_rf  output  1  register file write enable.
REQ-014 Port: rd_rf  output  2  register file write address.
REQ-015 Port: wdata_mm  output  256  result matrix to register file.

Function
REQ-016 Packing: element (r,col) SHALL occupy bits [(r*DIM+col)*ELEM_W +: ELEM_W]; row-major, unsigned.
REQ-017 Result element (r,col) SHALL be sum over k of A(r,k)*B(k,col), plus C(r,col) when acc=1, truncated to low 16 bits (mod 2^16).
REQ-018 States: IDLE, COMPUTE, WRITE; all outputs registered.
REQ-019 IDLE: busy=0; on an edge with start=1 and abort=0, latch a, b, c, acc into internal operand registers, clear element index to 0, go to COMPUTE.
REQ-020 COMPUTE: busy=1; each cycle compute one element (4 multiplies + adder tree) at current index into result register; index increments 0..15; after index 15 go to WRITE.
REQ-021 WRITE: busy=1, we_rf=1, rd_rf=2'd2, wdata_mm=full result, done=1 for exactly this cycle; next state IDLE.
REQ-022 Latency: start sampled at edge N -> we_rf/done high during cycle following edge N+17; busy high from edge N+1 through that cycle.
REQ-023 start while busy=1 SHALL be ignored (not queued).
REQ-024 Operand changes on a/b/c after the start edge SHALL NOT affect the result.
REQ-025 abort=1 in COMPUTE SHALL return to IDLE next edge with no we_rf pulse and no done; abort in WRITE SHALL NOT suppress the write already in progress.
REQ-026 abort and start both high in IDLE: abort wins, no operation starts.
REQ-027 Outside WRITE: we_rf=0, done=0; rd_rf and wdata_mm SHALL hold their last values.
REQ-028 Back-to-back: start high in the cycle IDLE is re-entered after WRITE SHALL begin a new operation on that edge.

Reset
REQ-029 reset=0 at a clock edge SHALL force state IDLE, busy=0, done=0, we_rf=0, rd_rf=2'd0, wdata_mm=0, index=0, operand registers 0.
REQ-030 reset=0 mid-COMPUTE SHALL discard the operation; no write-back after reset deasserts.
REQ-031 reset SHALL have priority over start and abort.

Verification
REQ-032 A=identity, B element(i)=i, acc=0, start pulse -> 17 cycles later we_rf=1, rd_rf=2, wdata_mm element(i)=i, done pulse 1 cycle.
REQ-033 A all 0x0002, B all 0x0003, acc=0 -> every result element 0x0018.
REQ-034 A all 0xFFFF, B all 0xFFFF -> every element 0x0004 (wrap check).
REQ-035 acc=1, C all 0x0005, A=identity, B all 0x0001 -> every element 0x0006; change c to 0 one cycle after start -> result unchanged.
REQ-036 start, then abort at COMPUTE index 8 -> busy drops next edge, no we_rf/done; repeat with reset=0 at index 8 -> same, all outputs at reset values.
REQ-037 start held high continuously for 40 cycles -> exactly two write-backs, 18 cycles apart, busy low only in the IDLE cycle between them.
